fb_writer: RTL and testbench
============================

Name: fb_writer

Overview:
- Write-side frame-buffer address generator: takes the camera pixel stream (hcount/vcount/pixel/valid) and produces BRAM write strobes into the 240x320 RGB565 frame buffer.
- Applies the same scale codes the display read path uses, so the written image maps 1:1 onto the scaled display read-out.
- Frames start and finish under a small FSM; an optional double-buffer ping-pongs between two frame halves.
- Sits between the camera pixel reconstructor and the frame-buffer BRAM write port.

Parameters:
- FB_W, 240, frame-buffer width in pixels.
- FB_H, 320, frame-buffer height in pixels.
- PIX_W, 16, pixel data width (RGB565).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- scale_in  input  2  scale code, sampled at frame start: 0 = 1:1, 2 = h/4 v/2, 3 = h/2 v/2, 1 = reserved.
- camera_valid_in  input  1  pixel strobe, one cycle per pixel.
- camera_hcount_in  input  11  camera column of the strobed pixel.
- camera_vcount_in  input  10  camera row of the strobed pixel.
- camera_pixel_in  input  PIX_W  pixel data.
- bram_we_out  output  1  write enable.
- bram_addr_out  output  18  write address; bit 17 is the buffer select.
- bram_data_out  output  PIX_W  write data.
- frame_done_out  output  1  one-cycle pulse when the last pixel of a frame is written.
- read_buffer_out  output  1  buffer index the display should read.
- frame_count_out  output  8  completed frames, wraps at 256.

Behaviour:
- Reset (async, rst_n_in low): all outputs 0; FSM = IDLE; latched scale = 0; write buffer = 0.
- FSM states:
  - IDLE: waits for camera_valid_in with h=0, v=0. Latches scale_in and goes to CAPTURE. That pixel is processed as the first pixel of the frame.
  - CAPTURE: processes valid pixels.
  - If scale_in = 1 is latched, the FSM stays in CAPTURE with no writes until the next (0,0) resync.
- Acceptance window (uses the latched scale; accepted pixels must also be valid):
  - Scale 0: accept h<240 and v<320; hs=h, vs=v.
  - Scale 2: accept h<960, v<640, h[1:0]==0 and v[0]==0; hs=h>>2, vs=v>>1.
  - Scale 3: accept h<480, v<640, h[0]==0 and v[0]==0; hs=h>>1, vs=v>>1.
  - Rejected pixels produce no write.
- Address: vs*240 + hs, computed shift-and-subtract as (vs<<8) − (vs<<4) + hs. Range 0..76799 in bits [16:0]. Bit 17 = write buffer.
- Pipeline: stage 1 registers the accept decision, hs/vs and the pixel; stage 2 registers address, data and we.
  - Latency from camera_valid_in to bram_we_out is 2 cycles, fully pipelined at 1 pixel/cycle.
  - bram_we_out is high for exactly one cycle per accepted pixel.
- Frame end: the accepted pixel with hs=239, vs=319 ends the frame.
  - frame_done_out pulses in the same cycle as that pixel's write.
  - frame_count_out increments in that cycle.
  - The FSM returns to IDLE on the cycle the last pixel is accepted.
- Resync: a valid (0,0) pixel while in CAPTURE aborts the current frame.
  - No frame_done, no buffer swap, no count change.
  - Scale is re-latched and the (0,0) pixel is written as pixel 0 of the new frame.
- scale_in changes mid-frame are ignored until the next frame start.
- A camera_valid_in gap of any length is tolerated; there is no timeout.
- Reset asserted mid-frame: pipeline contents are discarded; no write completes after reset assertion.

Optional Feature:
- Macro: FB_WRITER_DOUBLE_BUFFER_EN.
- Defined:
  - bram_addr_out[17] = write buffer.
  - On frame_done the write buffer toggles, and read_buffer_out takes the just-completed buffer in the same cycle.
  - Aborted frames do not toggle either buffer.
- Undefined: bram_addr_out[17] and read_buffer_out are tied to 0; single buffer, no swap logic.

Decomposition:
- Shared package fb_pkg holds:
  - scale code enum: SCALE_1X=0, SCALE_RSVD=1, SCALE_H4V2=2, SCALE_H2V2=3;
  - FB_W/FB_H constants, FB_ADDR_W=18, the PIX_W localparam;
  - FSM state typedef.
- One sub-module, fb_addr_calc: combinational scale/accept/hs-vs mapping plus shift-add address. It is reusable by the display read path.

Test Plan:
- Scale 0, full raster 240x320 from (0,0) → 76800 writes; first addr 0, addr for (239,319) = 76799; frame_done pulses once, 2 cycles after the last valid; frame_count 0→1.
- Scale 3, raster 640x480 → writes only for even h<480 and even v<640; pixel (2,2) → addr 241; (478,478) → addr 239*240+239=57599; no frame_done (vs never reaches 319).
- Scale 2, pixel (8,6) → addr 3*240+2=722; pixel (9,6) and (8,7) → no write.
- Resync: a (0,0) valid arrives mid-frame at 1000 pixels → no frame_done; the next write is addr 0; frame_count unchanged.
- With FB_WRITER_DOUBLE_BUFFER_EN: frame 1 writes have bit17=0; after frame_done, read_buffer_out=0 and frame 2 writes have bit17=1. Reset mid-frame → all outputs 0 immediately and no further we.
- Scale 1 latched → zero writes for the whole frame; scale_in toggled to 0 mid-frame → still zero writes until the next (0,0).

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the camera-to-frame-buffer write path.
package fb_pkg;

    localparam int unsigned FB_W      = 240;
    localparam int unsigned FB_H      = 320;
    localparam int unsigned FB_ADDR_W = 18;
    localparam int unsigned PIX_W     = 16;
    localparam int unsigned LIN_W     = FB_ADDR_W - 1;

    typedef enum logic [1:0] {
        SCALE_1X   = 2'd0,
        SCALE_RSVD = 2'd1,
        SCALE_H4V2 = 2'd2,
        SCALE_H2V2 = 2'd3
    } scale_e;

    typedef enum logic {
        StIdle,
        StCapture
    } state_e;

    // vs*240 + hs as (vs<<8) - (vs<<4) + hs, so no multiplier is needed.
    function automatic logic [LIN_W-1:0] fb_lin_addr(input logic [8:0] vs, input logic [7:0] hs);
        return {vs, 8'd0} - {4'd0, vs, 4'd0} + {9'd0, hs};
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational camera-coordinate to frame-buffer mapping: scale window, decimation and
// linear address. Shared with the display read path so both sides agree on placement.
module fb_addr_calc #(
    parameter int unsigned FB_W = fb_pkg::FB_W,
    parameter int unsigned FB_H = fb_pkg::FB_H
) (
    input  fb_pkg::scale_e                scale,
    input  logic [10:0]                   hcount,
    input  logic [9:0]                    vcount,
    output logic                          in_window,
    output logic [7:0]                    hs,
    output logic [8:0]                    vs,
    output logic [fb_pkg::LIN_W-1:0]      addr
);
    import fb_pkg::*;

    localparam logic [10:0] HLIM_1X = 11'(FB_W);
    localparam logic [10:0] HLIM_H4 = 11'(FB_W * 4);
    localparam logic [10:0] HLIM_H2 = 11'(FB_W * 2);
    localparam logic [9:0]  VLIM_1X = 10'(FB_H);
    localparam logic [9:0]  VLIM_V2 = 10'(FB_H * 2);

    always_comb begin
        in_window = 1'b0;
        hs        = '0;
        vs        = '0;
        unique case (scale)
            SCALE_1X: begin
                in_window = (hcount < HLIM_1X) && (vcount < VLIM_1X);
                hs        = hcount[7:0];
                vs        = vcount[8:0];
            end
            SCALE_H4V2: begin
                in_window = (hcount < HLIM_H4) && (vcount < VLIM_V2) &&
                            (hcount[1:0] == 2'b00) && !vcount[0];
                hs        = hcount[9:2];
                vs        = vcount[9:1];
            end
            SCALE_H2V2: begin
                in_window = (hcount < HLIM_H2) && (vcount < VLIM_V2) &&
                            !hcount[0] && !vcount[0];
                hs        = hcount[8:1];
                vs        = vcount[9:1];
            end
            SCALE_RSVD: in_window = 1'b0;
        endcase
    end

    assign addr = fb_lin_addr(vs, hs);

endmodule

// File: rtl/fb_writer.sv
// Camera pixel stream to frame-buffer BRAM write port, two-stage pipeline.
// Optional ping-pong buffering is enabled by defining FB_WRITER_DOUBLE_BUFFER_EN.
module fb_writer #(
    parameter int unsigned FB_W  = 240,
    parameter int unsigned FB_H  = 320,
    parameter int unsigned PIX_W = 16
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic [1:0]                     scale_in,
    input  logic                           camera_valid_in,
    input  logic [10:0]                    camera_hcount_in,
    input  logic [9:0]                     camera_vcount_in,
    input  logic [PIX_W-1:0]               camera_pixel_in,
    output logic                           bram_we_out,
    output logic [fb_pkg::FB_ADDR_W-1:0]   bram_addr_out,
    output logic [PIX_W-1:0]               bram_data_out,
    output logic                           frame_done_out,
    output logic                           read_buffer_out,
    output logic [7:0]                     frame_count_out
);
    import fb_pkg::*;

    localparam logic [7:0] HS_LAST = 8'(FB_W - 1);
    localparam logic [8:0] VS_LAST = 9'(FB_H - 1);

    state_e state_q, state_d;
    scale_e scale_q, scale_eff;

    logic             sof, in_window, accept, last, wbuf;
    logic [7:0]       hs;
    logic [8:0]       vs;
    logic [LIN_W-1:0] lin_addr;

    logic             s1_we, s1_last, s1_buf;
    logic [LIN_W-1:0] s1_addr;
    logic [PIX_W-1:0] s1_pix;

    logic             we_q, done_q, buf_q;
    logic [LIN_W-1:0] addr_q;
    logic [PIX_W-1:0] data_q;
    logic [7:0]       count_q;

    // A (0,0) strobe starts a frame from IDLE or resyncs from CAPTURE, using the fresh scale.
    assign sof       = camera_valid_in && (camera_hcount_in == '0) && (camera_vcount_in == '0);
    assign scale_eff = sof ? scale_e'(scale_in) : scale_q;

    fb_addr_calc #(
        .FB_W (FB_W),
        .FB_H (FB_H)
    ) u_addr_calc (
        .scale     (scale_eff),
        .hcount    (camera_hcount_in),
        .vcount    (camera_vcount_in),
        .in_window (in_window),
        .hs        (hs),
        .vs        (vs),
        .addr      (lin_addr)
    );

    assign accept = camera_valid_in && in_window && (sof || (state_q == StCapture));
    assign last   = accept && (hs == HS_LAST) && (vs == VS_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (sof) state_d = StCapture;
            StCapture: if (last && !sof) state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            scale_q <= SCALE_1X;
        end else begin
            state_q <= state_d;
            if (sof) scale_q <= scale_e'(scale_in);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_we   <= 1'b0;
            s1_last <= 1'b0;
            s1_buf  <= 1'b0;
            s1_addr <= '0;
            s1_pix  <= '0;
        end else begin
            s1_we   <= accept;
            s1_last <= last;
            s1_buf  <= wbuf;
            s1_addr <= lin_addr;
            s1_pix  <= camera_pixel_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            buf_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            we_q   <= s1_we;
            done_q <= s1_we && s1_last;
            buf_q  <= s1_buf;
            addr_q <= s1_addr;
            data_q <= s1_pix;
            if (s1_we && s1_last) count_q <= count_q + 8'd1;
        end
    end

`ifdef FB_WRITER_DOUBLE_BUFFER_EN
    logic wbuf_q, rbuf_q;

    // Write side flips as the last pixel enters the pipe; pixels behind it use the new buffer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wbuf_q <= 1'b0;
            rbuf_q <= 1'b0;
        end else begin
            if (last) wbuf_q <= ~wbuf_q;
            if (s1_we && s1_last) rbuf_q <= s1_buf;
        end
    end

    assign wbuf            = wbuf_q;
    assign read_buffer_out = rbuf_q;
`else
    assign wbuf            = 1'b0;
    assign read_buffer_out = 1'b0;
`endif

    assign bram_we_out     = we_q;
    assign bram_addr_out   = {buf_q, addr_q};
    assign bram_data_out   = data_q;
    assign frame_done_out  = done_q;
    assign frame_count_out = count_q;

endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: directed pixels carry hand-computed addresses; a negedge
// monitor pops and compares every write. Frame ends are reached with sparse rasters.
module tb_fb_writer;

`ifdef FB_WRITER_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    localparam logic [17:0] B17 = 18'h20000;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
        logic        done;
        logic [7:0]  count;
        logic        rbuf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  scale = 2'd0;
    logic        valid = 1'b0;
    logic [10:0] hc = '0;
    logic [9:0]  vc = '0;
    logic [15:0] pix = '0;
    logic        bram_we;
    logic [17:0] bram_addr;
    logic [15:0] bram_data;
    logic        frame_done;
    logic        read_buffer;
    logic [7:0]  frame_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_we = 0;
    int n_done = 0;
    int done_cyc = 0;
    int last_valid_cyc = 0;
    logic [17:0] last_addr = '0;
    logic [17:0] done_addr = '0;

    exp_t q[$];
    exp_t e;

    // Bench-side frame bookkeeping.
    bit m_wbuf = 1'b0;
    bit m_rbuf = 1'b0;
    int m_count = 0;

    fb_writer dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .scale_in         (scale),
        .camera_valid_in  (valid),
        .camera_hcount_in (hc),
        .camera_vcount_in (vc),
        .camera_pixel_in  (pix),
        .bram_we_out      (bram_we),
        .bram_addr_out    (bram_addr),
        .bram_data_out    (bram_data),
        .frame_done_out   (frame_done),
        .read_buffer_out  (read_buffer),
        .frame_count_out  (frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bram_we) begin
            n_we++;
            last_addr = bram_addr;
            chk("write_expected", 64'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("addr", bram_addr, e.addr);
                chk("data", bram_data, e.data);
                chk("frame_done", frame_done, e.done);
                chk("frame_count", frame_count, e.count);
                chk("read_buffer", read_buffer, e.rbuf);
            end
            if (frame_done) begin
                n_done++;
                done_cyc  = cyc;
                done_addr = bram_addr;
            end
        end else if (frame_done) begin
            chk("done_without_we", 1, 0);
        end
    end

    // exp_addr: hand-computed 17-bit address, or -1 when the pixel must not be written.
    task automatic send(input int h, input int v, input int exp_addr);
        exp_t x;
        logic [15:0] p;
        p = 16'(h * 7 + v * 131 + 16'h1234);
        if (exp_addr >= 0) begin
            x.addr = {m_wbuf, 17'(exp_addr)};
            x.data = p;
            x.done = (exp_addr == 76799);
            if (x.done) begin
                m_count++;
                m_rbuf = m_wbuf;
                m_wbuf = m_wbuf ^ DB;
            end
            x.count = 8'(m_count);
            x.rbuf  = m_rbuf;
            q.push_back(x);
        end
        hc = 11'(h);
        vc = 10'(v);
        pix = p;
        valid = 1'b1;
        last_valid_cyc = cyc;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, bram_we, 0);
        chk({tag, "_addr"}, bram_addr, 0);
        chk({tag, "_data"}, bram_data, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_rbuf"}, read_buffer, 0);
        chk({tag, "_count"}, frame_count, 0);
    endtask

    initial begin
        int we0, done0, a_cyc;

        idle(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Scale 1:1 frame: rows 0,1 and 319; h 240..243 of row 0 lie outside the window.
        scale = 2'd0;
        we0 = n_we;
        for (int h = 0; h < 244; h++) send(h, 0, (h < 240) ? h : -1);
        for (int h = 0; h < 240; h++) send(h, 1, 240 + h);
        for (int h = 0; h < 240; h++) send(h, 319, 319 * 240 + h);
        a_cyc = last_valid_cyc;
        idle(4);
        chk("s0_writes", n_we - we0, 720);
        chk("s0_done_count", n_done, 1);
        chk("s0_last_addr", done_addr, 76799);
        chk("s0_done_latency", done_cyc - a_cyc, 2);
        chk("s0_frame_count", frame_count, 1);
        chk("s0_read_buffer", read_buffer, 0);

        // Scale h/2 v/2 with a mid-frame scale_in change that must be ignored.
        scale = 2'd3;
        we0 = n_we;
        send(0, 0, 0);
        send(1, 0, -1);
        send(2, 0, 1);
        send(2, 2, 241);
        send(3, 2, -1);
        send(2, 3, -1);
        send(478, 478, 57599);
        send(480, 478, -1);
        send(478, 640, -1);
        scale = 2'd0;
        send(200, 4, 580);
        idle(4);
        chk("s3_writes", n_we - we0, 5);
        chk("s3_last_addr", last_addr, (DB ? B17 : 18'd0) | 18'd580);
        chk("s3_no_done", n_done, 1);

        // Scale h/4 v/2, entered by resync from CAPTURE.
        scale = 2'd2;
        we0 = n_we;
        send(0, 0, 0);
        send(8, 6, 722);
        send(9, 6, -1);
        send(8, 7, -1);
        send(960, 0, -1);
        idle(4);
        chk("s2_writes", n_we - we0, 2);
        chk("s2_last_addr", last_addr, (DB ? B17 : 18'd0) | 18'd722);

        // 1000 pixels, then a resync that re-latches scale 3 and restarts at address 0.
        scale = 2'd0;
        we0 = n_we;
        done0 = n_done;
        send(0, 0, 0);
        for (int i = 1; i < 1000; i++) send(i % 240, i / 240, i);
        scale = 2'd3;
        send(0, 0, 0);
        idle(3);
        chk("resync_addr0", last_addr, DB ? B17 : 18'd0);
        send(2, 2, 241);
        send(5, 0, -1);
        idle(4);
        chk("resync_writes", n_we - we0, 1002);
        chk("resync_no_done", n_done - done0, 0);
        chk("resync_count", frame_count, 1);

        // Finish the resynced frame at scale 3 with the last mapped pixel.
        send(956, 638, -1);
        send(478, 638, 76799);
        idle(4);
        chk("f2_done_count", n_done, 2);
        chk("f2_frame_count", frame_count, 2);
        chk("f2_done_addr", done_addr, (DB ? B17 : 18'd0) | 18'd76799);
        chk("f2_read_buffer", read_buffer, DB);

        // Reserved scale latched: nothing written until the next (0,0).
        scale = 2'd1;
        we0 = n_we;
        send(0, 0, -1);
        scale = 2'd0;
        send(1, 0, -1);
        send(0, 1, -1);
        send(239, 319, -1);
        idle(4);
        chk("rsvd_writes", n_we - we0, 0);
        chk("rsvd_no_done", n_done, 2);

        // Restart, then reset with pixels still in the pipe.
        send(0, 0, 0);
        send(1, 0, 1);
        send(2, 0, 2);
        chk("pre_reset_we", bram_we, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        q.delete();
        m_wbuf = 1'b0;
        m_rbuf = 1'b0;
        m_count = 0;
        we0 = n_we;
        idle(4);
        chk("reset_no_we", n_we - we0, 0);
        rst_n = 1'b1;
        idle(2);

        // Short frame after reset: counters and buffers start from zero again.
        done0 = n_done;
        send(0, 0, 0);
        send(239, 319, 76799);
        idle(4);
        chk("post_reset_done", n_done - done0, 1);
        chk("post_reset_addr", done_addr, 76799);
        chk("post_reset_count", frame_count, 1);

        idle(3);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
